// File: rtl/riscv_irq_pending_unit.sv
// ============================================================================
//  Module      : riscv_irq_pending_unit
//  Description : Conditions raw interrupt lines into the level-style irq
//                vector consumed by the exception controller. Per line:
//                optional synchronisation, rising-edge detection, pending
//                storage (edge lines) or pass-through (level lines), CSR
//                masking, ack-based clear, and sticky "missed edge" flags.
//                Optional feature macro: IRQ_SYNC_EN (two-flop synchroniser
//                on irq_src_i; adds two cycles of latency).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module riscv_irq_pending_unit #(
  parameter int                   NUM_IRQ   = 32,
  parameter logic [NUM_IRQ-1:0]   EDGE_TRIG = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_src_i,
  input  logic [NUM_IRQ-1:0] irq_mask_i,
  input  logic [NUM_IRQ-1:0] sw_set_i,
  input  logic               ack_i,
  input  logic [5:0]         ack_cause_i,
  input  logic [NUM_IRQ-1:0] missed_clr_i,
  output logic [NUM_IRQ-1:0] irq_o,
  output logic               irq_valid_o,
  output logic [4:0]         irq_id_o,
  output logic [NUM_IRQ-1:0] missed_o
);

  // Conditioned source seen by the edge detector and the level path
  logic [NUM_IRQ-1:0] src_s;

  // Edge-detect and pending state
  logic [NUM_IRQ-1:0] prev_q,   prev_d;
  logic [NUM_IRQ-1:0] pend_q,   pend_d;
  logic [NUM_IRQ-1:0] missed_q, missed_d;

  // Per-line event vectors
  logic [NUM_IRQ-1:0] edge_vec;
  logic [NUM_IRQ-1:0] set_vec;
  logic [NUM_IRQ-1:0] clr_vec;

`ifdef IRQ_SYNC_EN
  // Two-flop synchroniser; sources may be asynchronous to clk
  logic [NUM_IRQ-1:0] sync1_q, sync1_d;
  logic [NUM_IRQ-1:0] sync2_q, sync2_d;

  // Next state of the synchroniser chain
  always_comb begin
    sync1_d = irq_src_i;
    sync2_d = sync1_q;
  end

  // Synchroniser flops, cleared asynchronously so no stale level survives reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign src_s = sync2_q;
`else
  // Sources are already synchronous to clk; use them directly
  assign src_s = irq_src_i;
`endif

  // Rising-edge detection, set and clear events for every line
  always_comb begin
    prev_d   = src_s;
    edge_vec = src_s & ~prev_q;
    set_vec  = edge_vec | sw_set_i;
    clr_vec  = '0;
    // Only an interrupt cause (bit5) retires a pending line; synchronous
    // exceptions share the ack strobe but must not touch pending state.
    if (ack_i && ack_cause_i[5]) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (ack_cause_i[4:0] == 5'(i)) begin
          clr_vec[i] = 1'b1;
        end
      end
    end
  end

  // Pending and missed next-state per line, chosen by trigger type
  always_comb begin
    pend_d   = '0;
    missed_d = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (EDGE_TRIG[i]) begin
        // A new set beats a same-cycle clear so no request is lost
        pend_d[i]   = set_vec[i] | (pend_q[i] & ~clr_vec[i]);
        // A set that lands on a still-pending line is a lost edge; a new
        // miss wins over the software clear of the flag.
        missed_d[i] = (set_vec[i] & pend_q[i] & ~clr_vec[i]) |
                      (missed_q[i] & ~missed_clr_i[i]);
      end else begin
        // Level lines store nothing: the bit tracks the source
        pend_d[i]   = src_s[i] | sw_set_i[i];
        missed_d[i] = 1'b0;
      end
    end
  end

  // State registers; reset loses all pending and missed state at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= '0;
      pend_q   <= '0;
      missed_q <= '0;
    end else begin
      prev_q   <= prev_d;
      pend_q   <= pend_d;
      missed_q <= missed_d;
    end
  end

  // Masked vector and summary; mask acts combinationally and never clears state
  always_comb begin
    irq_o       = pend_q & irq_mask_i;
    irq_valid_o = |irq_o;
    missed_o    = missed_q;
  end

  // Lowest index wins, matching the exception-controller priority
  always_comb begin
    irq_id_o = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_o[i]) begin
        irq_id_o = 5'(i);
      end
    end
  end

endmodule

`default_nettype wire
